// File: rtl/fft8_pkg.sv
// Shared constants, twiddle table and state encoding for the 8-point FFT frame sequencer.
package fft8_pkg;

    localparam int N_PTS    = 8;
    localparam int SAMPLE_W = 16;
    localparam int TW_FRAC  = 14;

    // Q1.14 twiddles W_k = exp(-j*2*pi*k/8); 11585 is round(2^14 / sqrt(2))
    localparam logic signed [SAMPLE_W-1:0] TW_ONE = SAMPLE_W'(1 << TW_FRAC);
    localparam logic signed [SAMPLE_W-1:0] TW_R2  = 16'sd11585;

    localparam logic signed [SAMPLE_W-1:0] W0_RE = TW_ONE;
    localparam logic signed [SAMPLE_W-1:0] W0_IM = 16'sd0;
    localparam logic signed [SAMPLE_W-1:0] W1_RE = TW_R2;
    localparam logic signed [SAMPLE_W-1:0] W1_IM = -TW_R2;
    localparam logic signed [SAMPLE_W-1:0] W2_RE = 16'sd0;
    localparam logic signed [SAMPLE_W-1:0] W2_IM = -TW_ONE;
    localparam logic signed [SAMPLE_W-1:0] W3_RE = -TW_R2;
    localparam logic signed [SAMPLE_W-1:0] W3_IM = -TW_R2;

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        UNLOAD,
        FULL
    } state_e;

endpackage

// File: rtl/fft8_result_mux.sv
// Registered 8:1 selector that presents one captured FFT bin on the output stream.
module fft8_result_mux
    import fft8_pkg::*;
#(
    parameter int OUT_W = 67
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [2:0]       sel,
    input  logic [OUT_W-1:0] res_re [N_PTS],
    input  logic [OUT_W-1:0] res_im [N_PTS],
    output logic [OUT_W-1:0] data_re,
    output logic [OUT_W-1:0] data_im
);

    logic [OUT_W-1:0] data_re_q, data_re_d;
    logic [OUT_W-1:0] data_im_q, data_im_d;

    always_comb begin
        data_re_d = data_re_q;
        data_im_d = data_im_q;
        if (load) begin
            data_re_d = res_re[sel];
            data_im_d = res_im[sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_re_q <= '0;
            data_im_q <= '0;
        end else begin
            data_re_q <= data_re_d;
            data_im_q <= data_im_d;
        end
    end

    assign data_re = data_re_q;
    assign data_im = data_im_q;

endmodule

// File: rtl/fft8_sequencer.sv
// Frame sequencer for the 8-point combinational FFT core: load 8 samples, settle, capture, stream bins.
// Optional FFT_PINGPONG_EN lets the next frame load while the previous results unload.
module fft8_sequencer
    import fft8_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int OUT_W         = 67
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [127:0]         fft_x,
    output logic [63:0]          fft_tw_re,
    output logic [63:0]          fft_tw_im,
    input  logic [8*OUT_W-1:0]   fft_y_re,
    input  logic [8*OUT_W-1:0]   fft_y_im,
    output logic [OUT_W-1:0]     m_real,
    output logic [OUT_W-1:0]     m_imag,
    output logic [2:0]           m_bin,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 busy
);

    localparam logic [2:0] LAST_IDX    = 3'(N_PTS - 1);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [3:0]            settle_q, settle_d;
    logic [SAMPLE_W-1:0]   slot_q [N_PTS];
    logic [SAMPLE_W-1:0]   slot_d [N_PTS];
    logic [OUT_W-1:0]      res_re_q [N_PTS];
    logic [OUT_W-1:0]      res_re_d [N_PTS];
    logic [OUT_W-1:0]      res_im_q [N_PTS];
    logic [OUT_W-1:0]      res_im_d [N_PTS];
    logic [OUT_W-1:0]      y_re_w [N_PTS];
    logic [OUT_W-1:0]      y_im_w [N_PTS];
    logic [2:0]            bin_q, bin_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  s_ready_q, s_ready_d;
    logic                  busy_q, busy_d;

    logic                  accept;
    logic                  frame_done;
    logic                  beat;
    logic                  last_beat;
    logic                  unload_active;
    logic                  capture;
    logic                  mux_load;

    assign fft_tw_re = {W3_RE, W2_RE, W1_RE, W0_RE};
    assign fft_tw_im = {W3_IM, W2_IM, W1_IM, W0_IM};

    for (genvar g = 0; g < N_PTS; g++) begin : g_slices
        assign fft_x[SAMPLE_W*g +: SAMPLE_W] = slot_q[g];
        assign y_re_w[g] = fft_y_re[OUT_W*g +: OUT_W];
        assign y_im_w[g] = fft_y_im[OUT_W*g +: OUT_W];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        settle_d  = settle_q;
        slot_d    = slot_q;
        res_re_d  = res_re_q;
        res_im_d  = res_im_q;
        bin_d     = bin_q;
        m_valid_d = m_valid_q;
        capture   = 1'b0;
        mux_load  = 1'b0;

        accept        = s_valid && s_ready_q;
        frame_done    = accept && (cnt_q == LAST_IDX);
        beat          = m_valid_q && m_ready;
        last_beat     = beat && (bin_q == LAST_IDX);
        unload_active = (state_q == UNLOAD) || (state_q == FULL);

        if (accept) begin
            slot_d[cnt_q] = s_data;
            cnt_d         = cnt_q + 3'd1;
        end

        // The mux is loaded with the bin that will be current after this edge,
        // so m_real/m_imag always line up with m_bin without a bubble.
        if (unload_active) begin
            if (!m_valid_q) begin
                m_valid_d = 1'b1;
                bin_d     = 3'd0;
                mux_load  = 1'b1;
            end else if (last_beat) begin
                m_valid_d = 1'b0;
                bin_d     = 3'd0;
            end else if (beat) begin
                bin_d    = bin_q + 3'd1;
                mux_load = 1'b1;
            end
        end

        unique case (state_q)
            LOAD: begin
                if (frame_done) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_INIT;
                end
            end
            SETTLE: begin
                if (settle_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = UNLOAD;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            UNLOAD: begin
`ifdef FFT_PINGPONG_EN
                if (frame_done && last_beat) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_INIT;
                end else if (frame_done) begin
                    state_d = FULL;
                end else if (last_beat) begin
                    state_d = LOAD;
                end
`else
                if (last_beat) begin
                    state_d = LOAD;
                end
`endif
            end
`ifdef FFT_PINGPONG_EN
            FULL: begin
                if (last_beat) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_INIT;
                end
            end
`endif
            default: begin
                state_d = LOAD;
            end
        endcase

        if (capture) begin
            res_re_d = y_re_w;
            res_im_d = y_im_w;
        end

        m_last_d = m_valid_d && (bin_d == LAST_IDX);
`ifdef FFT_PINGPONG_EN
        s_ready_d = (state_d == LOAD) || (state_d == UNLOAD);
`else
        s_ready_d = (state_d == LOAD);
`endif
        busy_d = !((state_d == LOAD) && (cnt_d == 3'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            settle_q  <= '0;
            bin_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            for (int i = 0; i < N_PTS; i++) begin
                slot_q[i]   <= '0;
                res_re_q[i] <= '0;
                res_im_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            settle_q  <= settle_d;
            bin_q     <= bin_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            slot_q    <= slot_d;
            res_re_q  <= res_re_d;
            res_im_q  <= res_im_d;
        end
    end

    fft8_result_mux #(
        .OUT_W (OUT_W)
    ) u_result_mux (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mux_load),
        .sel     (bin_d),
        .res_re  (res_re_q),
        .res_im  (res_im_q),
        .data_re (m_real),
        .data_im (m_imag)
    );

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_bin   = bin_q;
    assign busy    = busy_q;

endmodule
